// File: rtl/uart_host_ctrl_if.sv
// Signal bundle between the CoreUART parallel port, the ISP byte streams and the status block.
// The master modport is the host controller; the slave modport is its environment.
interface uart_host_ctrl_if;
    logic        UART_CSN;
    logic        UART_OEN;
    logic        UART_WEN;
    logic [7:0]  UART_DATA_IN;
    logic [7:0]  UART_DATA_OUT;
    logic        UART_RXRDY;
    logic        UART_TXRDY;
    logic        UART_PARITY_ERR;
    logic        UART_FRAMING_ERR;
    logic        UART_OVERFLOW;
    logic [12:0] UART_BAUD_VAL;
    logic        UART_BIT8;
    logic        UART_PARITY_EN;
    logic        UART_ODD_N_EVEN;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        TX_READY;
    logic [7:0]  RX_DATA;
    logic [1:0]  RX_ERR;
    logic        RX_VALID;
    logic        RX_READY;
    logic        STAT_CLR;
    logic        STAT_PERR;
    logic        STAT_FERR;
    logic        STAT_OVF;
    logic [15:0] RX_COUNT;
    logic [15:0] TX_COUNT;

    modport master (
        output UART_CSN, UART_OEN, UART_WEN, UART_DATA_IN,
        input  UART_DATA_OUT, UART_RXRDY, UART_TXRDY,
        input  UART_PARITY_ERR, UART_FRAMING_ERR, UART_OVERFLOW,
        output UART_BAUD_VAL, UART_BIT8, UART_PARITY_EN, UART_ODD_N_EVEN,
        input  TX_DATA, TX_VALID,
        output TX_READY,
        output RX_DATA, RX_ERR, RX_VALID,
        input  RX_READY,
        input  STAT_CLR,
        output STAT_PERR, STAT_FERR, STAT_OVF, RX_COUNT, TX_COUNT
    );

    modport slave (
        input  UART_CSN, UART_OEN, UART_WEN, UART_DATA_IN,
        output UART_DATA_OUT, UART_RXRDY, UART_TXRDY,
        output UART_PARITY_ERR, UART_FRAMING_ERR, UART_OVERFLOW,
        input  UART_BAUD_VAL, UART_BIT8, UART_PARITY_EN, UART_ODD_N_EVEN,
        output TX_DATA, TX_VALID,
        input  TX_READY,
        input  RX_DATA, RX_ERR, RX_VALID,
        output RX_READY,
        output STAT_CLR,
        input  STAT_PERR, STAT_FERR, STAT_OVF, RX_COUNT, TX_COUNT
    );
endinterface

// File: rtl/uart_host_ctrl.sv
// Bus initiator for the CoreUART parallel port: arbitrates RX reads and TX writes,
// buffers received bytes in a 2-entry FIFO and keeps sticky error flags and byte counters.
module uart_host_ctrl #(
    parameter logic [12:0] BAUD_DIV   = 13'd0,
    parameter bit          CFG_BIT8   = 1'b1,
    parameter bit          CFG_PAR_EN = 1'b0,
    parameter bit          CFG_ODD    = 1'b0,
    parameter int unsigned HOLDOFF    = 2
) (
    input  logic             CLK,
    input  logic             RESET_N,
    uart_host_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, HOLD} state_t;

    localparam logic [2:0] HOLD_LAST = 3'(HOLDOFF - 1);

    state_t      state_q, state_d;
    logic [2:0]  hold_q, hold_d;
    logic        last_rx_q, last_rx_d;
    logic        csn_q, csn_d, oen_q, oen_d, wen_q, wen_d;
    logic [7:0]  din_q, din_d;
    logic [9:0]  fifo_q [2];
    logic [9:0]  fifo_d [2];
    logic        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;
    logic [15:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;

    logic rx_req, tx_req, grant_rx, grant_tx, tx_ready, push, pop;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        last_rx_d = last_rx_q;
        csn_d     = 1'b1;
        oen_d     = 1'b1;
        wen_d     = 1'b1;
        din_d     = din_q;
        fifo_d    = fifo_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;

        rx_req   = bus.UART_RXRDY & (cnt_q != 2'd2);
        tx_req   = bus.TX_VALID & bus.UART_TXRDY;
        // On a tie the stream that did not go last wins, so neither can starve.
        grant_rx = rx_req & (~tx_req | ~last_rx_q);
        grant_tx = tx_req & (~rx_req | last_rx_q);
        tx_ready = (state_q == IDLE) & bus.UART_TXRDY & grant_tx;
        push     = (state_q == RD);
        pop      = (cnt_q != 2'd0) & bus.RX_READY;

        // Strobes are registered: they are loaded on the edge that enters RD/WR.
        case (state_q)
            IDLE: begin
                if (grant_rx) begin
                    state_d = RD;
                    csn_d   = 1'b0;
                    oen_d   = 1'b0;
                end else if (tx_ready) begin
                    state_d = WR;
                    din_d   = bus.TX_DATA;
                    csn_d   = 1'b0;
                    wen_d   = 1'b0;
                end
            end
            RD: begin
                state_d   = HOLD;
                hold_d    = HOLD_LAST;
                last_rx_d = 1'b1;
            end
            WR: begin
                state_d   = HOLD;
                hold_d    = HOLD_LAST;
                last_rx_d = 1'b0;
            end
            default: begin
                if (hold_q == 3'd0) state_d = IDLE;
                else                hold_d  = hold_q - 3'd1;
            end
        endcase

        if (push) begin
            fifo_d[wr_ptr_q] = {bus.UART_FRAMING_ERR, bus.UART_PARITY_ERR, bus.UART_DATA_OUT};
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};

        // Clear first, then let a same-cycle event land on the cleared value.
        perr_d   = (bus.STAT_CLR ? 1'b0  : perr_q)   | (push & bus.UART_PARITY_ERR);
        ferr_d   = (bus.STAT_CLR ? 1'b0  : ferr_q)   | (push & bus.UART_FRAMING_ERR);
        ovf_d    = (bus.STAT_CLR ? 1'b0  : ovf_q)    | bus.UART_OVERFLOW;
        rx_cnt_d = (bus.STAT_CLR ? 16'd0 : rx_cnt_q) + {15'd0, push};
        tx_cnt_d = (bus.STAT_CLR ? 16'd0 : tx_cnt_q) + {15'd0, state_q == WR};
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            hold_q    <= 3'd0;
            last_rx_q <= 1'b0;
            csn_q     <= 1'b1;
            oen_q     <= 1'b1;
            wen_q     <= 1'b1;
            din_q     <= 8'd0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            cnt_q     <= 2'd0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
            rx_cnt_q  <= 16'd0;
            tx_cnt_q  <= 16'd0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            last_rx_q <= last_rx_d;
            csn_q     <= csn_d;
            oen_q     <= oen_d;
            wen_q     <= wen_d;
            din_q     <= din_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovf_q     <= ovf_d;
            rx_cnt_q  <= rx_cnt_d;
            tx_cnt_q  <= tx_cnt_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            always_ff @(posedge CLK or negedge RESET_N) begin
                if (!RESET_N) fifo_q[gi] <= 10'd0;
                else          fifo_q[gi] <= fifo_d[gi];
            end
        end
    endgenerate

    assign bus.UART_CSN        = csn_q;
    assign bus.UART_OEN        = oen_q;
    assign bus.UART_WEN        = wen_q;
    assign bus.UART_DATA_IN    = din_q;
    assign bus.UART_BAUD_VAL   = BAUD_DIV;
    assign bus.UART_BIT8       = CFG_BIT8;
    assign bus.UART_PARITY_EN  = CFG_PAR_EN;
    assign bus.UART_ODD_N_EVEN = CFG_ODD;
    assign bus.TX_READY        = tx_ready;
    assign bus.RX_DATA         = fifo_q[rd_ptr_q][7:0];
    assign bus.RX_ERR          = fifo_q[rd_ptr_q][9:8];
    assign bus.RX_VALID        = (cnt_q != 2'd0);
    assign bus.STAT_PERR       = perr_q;
    assign bus.STAT_FERR       = ferr_q;
    assign bus.STAT_OVF        = ovf_q;
    assign bus.RX_COUNT        = rx_cnt_q;
    assign bus.TX_COUNT        = tx_cnt_q;
endmodule
